// File: rtl/memctrl_host_if.sv
// memctrl_host_if: host valid/ready front end that sequences single-beat requests onto the memory controller pins
// Ports: CLK, RST (synchronous, active-high); REQ_VALID/REQ_READY/REQ_WRITE/REQ_ADDR/REQ_WDATA request side;
// RSP_VALID/RSP_WRITE/RSP_RDATA response side, plus RSP_READY when MEMHOST_RSP_BP_EN is defined;
// M_ADDR/M_CE/M_CSB/M_WEB/M_OEB/M_IDATA controller pins (all registered), M_ODATA controller read data.
// Optional feature macro: MEMHOST_RSP_BP_EN (response backpressure; undefined = one-cycle response).
module memctrl_host_if #(
    parameter int RD_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WRITE,
    input  logic [15:0] REQ_ADDR,
    input  logic [7:0]  REQ_WDATA,
    output logic        RSP_VALID,
    output logic        RSP_WRITE,
    output logic [7:0]  RSP_RDATA,
`ifdef MEMHOST_RSP_BP_EN
    input  logic        RSP_READY,
`endif
    output logic [15:0] M_ADDR,
    output logic        M_CE,
    output logic        M_CSB,
    output logic        M_WEB,
    output logic        M_OEB,
    output logic [7:0]  M_IDATA,
    input  logic [7:0]  M_ODATA
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RESP} state_t;
    state_t state, state_n;
    logic [3:0] cnt;
    logic wr_q, wr_d, accept, capture, resp_done, pins_on;
    logic [15:0] addr_q, addr_d, addr_n;
    logic [7:0] wdata_q, wdata_d, idata_n, rdata_n;
    logic ready_n, web_n, oeb_n, rvalid_n, rwrite_n;

    assign accept  = state == IDLE && REQ_VALID;
    assign capture = state == STROBE && !wr_q && cnt == 4'd0;
    // next-cycle view of the latched request, so pins are correct in the SETUP cycle right after accept
    assign wr_d    = accept ? REQ_WRITE : wr_q;
    assign addr_d  = accept ? REQ_ADDR : addr_q;
    assign wdata_d = accept ? REQ_WDATA : wdata_q;
`ifdef MEMHOST_RSP_BP_EN
    assign resp_done = RSP_READY;
`else
    assign resp_done = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            wr_q      <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 8'h00;
            REQ_READY <= 1'b1;
            RSP_VALID <= 1'b0;
            RSP_WRITE <= 1'b0;
            RSP_RDATA <= 8'h00;
            M_ADDR    <= 16'h0000;
            M_CE      <= 1'b0;
            M_CSB     <= 1'b1;
            M_WEB     <= 1'b1;
            M_OEB     <= 1'b1;
            M_IDATA   <= 8'h00;
        end else begin
            state     <= state_n;
            cnt       <= state == SETUP ? 4'(RD_LAT - 1) : (state == STROBE && cnt != 4'd0) ? cnt - 4'd1 : cnt;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            REQ_READY <= ready_n;
            RSP_VALID <= rvalid_n;
            RSP_WRITE <= rwrite_n;
            RSP_RDATA <= rdata_n;
            M_ADDR    <= addr_n;
            M_CE      <= pins_on;
            M_CSB     <= !pins_on;
            M_WEB     <= web_n;
            M_OEB     <= oeb_n;
            M_IDATA   <= idata_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (REQ_VALID) state_n = SETUP;
            SETUP:  state_n = STROBE;
            STROBE: if (wr_q || cnt == 4'd0) state_n = RESP;
            RESP:   if (resp_done) state_n = IDLE;
        endcase
    end

    // outputs are registered, so they are decoded from the state being entered
    always_comb begin
        pins_on  = state_n == SETUP || state_n == STROBE;
        ready_n  = state_n == IDLE;
        addr_n   = pins_on ? addr_d : 16'h0000;
        idata_n  = pins_on ? wdata_d : 8'h00;
        web_n    = !(state_n == STROBE && wr_d);
        oeb_n    = !(state_n == STROBE && !wr_d);
        rvalid_n = state_n == RESP;
        rwrite_n = state_n == RESP && wr_d;
        // RSP_RDATA is zero outside RESP, so a write response naturally reports 0x00
        rdata_n  = capture ? M_ODATA : (state_n == RESP ? RSP_RDATA : 8'h00);
    end
endmodule

// File: tb/tb_memctrl_host_if.sv
// tb_memctrl_host_if: randomized self-checking bench for memctrl_host_if, two instances (RD_LAT=1 and RD_LAT=3)
// Ports: none; each instance sees a simple behavioural SRAM on its pins, expectations come from a reference store.
// Honours MEMHOST_RSP_BP_EN (adds the RSP_READY connection and a backpressure scenario).
module tb_memctrl_host_if;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst [2];
    logic        req_valid [2], req_ready [2], req_write [2];
    logic [15:0] req_addr [2], m_addr [2];
    logic [7:0]  req_wdata [2], rsp_rdata [2], m_idata [2];
    logic        rsp_valid [2], rsp_write [2];
    logic        m_ce [2], m_csb [2], m_web [2], m_oeb [2];
`ifdef MEMHOST_RSP_BP_EN
    logic        rsp_ready [2];
`endif
    int lat [2] = '{1, 3};
    logic [7:0] ref_mem [2][65536];
    int errors = 0;
    int checks = 0;

    localparam logic [29:0] IDLE_PINS = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00};

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] mem [65536];
        logic [7:0] odata;
        memctrl_host_if #(.RD_LAT(g == 0 ? 1 : 3)) dut (
            .CLK(CLK), .RST(rst[g]),
            .REQ_VALID(req_valid[g]), .REQ_READY(req_ready[g]), .REQ_WRITE(req_write[g]),
            .REQ_ADDR(req_addr[g]), .REQ_WDATA(req_wdata[g]),
            .RSP_VALID(rsp_valid[g]), .RSP_WRITE(rsp_write[g]), .RSP_RDATA(rsp_rdata[g]),
`ifdef MEMHOST_RSP_BP_EN
            .RSP_READY(rsp_ready[g]),
`endif
            .M_ADDR(m_addr[g]), .M_CE(m_ce[g]), .M_CSB(m_csb[g]), .M_WEB(m_web[g]),
            .M_OEB(m_oeb[g]), .M_IDATA(m_idata[g]), .M_ODATA(odata)
        );
        always @(posedge CLK) if (!m_web[g]) mem[m_addr[g]] <= m_idata[g];
        // junk value when not output-enabled exposes a capture on the wrong cycle
        assign odata = m_oeb[g] ? 8'h5A : mem[m_addr[g]];
    end

    function automatic logic [29:0] obs(input int k);
        return {req_ready[k], rsp_valid[k], m_ce[k], m_csb[k], m_web[k], m_oeb[k], m_addr[k], m_idata[k]};
    endfunction

    function automatic logic [29:0] pins(input logic rdy, input logic rv, input logic ce, input logic web,
                                         input logic oeb, input logic [15:0] a, input logic [7:0] d);
        return {rdy, rv, ce, !ce, web, oeb, a, d};
    endfunction

    task automatic do_txn(input int k, input logic wr, input logic [15:0] a, input logic [7:0] d);
        int n;
        logic [7:0] exp_rd;
        logic [29:0] exp;
        n = 0;
        while (!req_ready[k] && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        checks++;
        if (req_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL txn_ready_timeout inst=%0d got=%b want=1", k, req_ready[k]);
        end
        req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = a; req_wdata[k] = d;
        @(posedge CLK); #1;
        // keep REQ_VALID high with junk fields while busy: must be ignored
        req_write[k] = 1'($urandom); req_addr[k] = 16'($urandom); req_wdata[k] = 8'($urandom);
        exp = pins(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, a, d);
        checks++;
        if (obs(k) !== exp) begin
            errors++;
            $display("FAIL setup inst=%0d got=%h want=%h", k, obs(k), exp);
        end
        for (int i = 0; i < (wr ? 1 : lat[k]); i++) begin
            @(posedge CLK); #1;
            exp = pins(1'b0, 1'b0, 1'b1, !wr, wr, a, d);
            checks++;
            if (obs(k) !== exp) begin
                errors++;
                $display("FAIL strobe inst=%0d cyc=%0d got=%h want=%h", k, i, obs(k), exp);
            end
        end
        @(posedge CLK); #1;
        req_valid[k] = 1'b0;
        exp_rd = wr ? 8'h00 : ref_mem[k][a];
        if (wr) ref_mem[k][a] = d;
        exp = pins(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00);
        checks++;
        if ({obs(k), rsp_write[k], rsp_rdata[k]} !== {exp, wr, exp_rd}) begin
            errors++;
            $display("FAIL resp inst=%0d got=%h/%b/%h want=%h/%b/%h", k, obs(k), rsp_write[k], rsp_rdata[k],
                     exp, wr, exp_rd);
        end
        @(posedge CLK); #1;
        checks++;
        if (obs(k) !== IDLE_PINS) begin
            errors++;
            $display("FAIL back_to_idle inst=%0d got=%h want=%h", k, obs(k), IDLE_PINS);
        end
    endtask

    task automatic test_reset();
        rst[0] = 1'b1; rst[1] = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({obs(k), rsp_write[k], rsp_rdata[k]} !== {IDLE_PINS, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL reset inst=%0d got=%h/%b/%h want=%h/0/00", k, obs(k), rsp_write[k], rsp_rdata[k],
                         IDLE_PINS);
            end
        end
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 16'h4444;
        @(posedge CLK); #1;
        rst[0] = 1'b0; rst[1] = 1'b0; req_valid[0] = 1'b0;
        checks++;
        if (obs(0) !== IDLE_PINS) begin
            errors++;
            $display("FAIL valid_with_reset got=%h want=%h", obs(0), IDLE_PINS);
        end
    endtask

    task automatic test_write_read();
        do_txn(0, 1'b1, 16'h1234, 8'hA5);
        do_txn(0, 1'b0, 16'h1234, 8'h3E);
        do_txn(1, 1'b1, 16'hFFFF, 8'h3C);
        do_txn(1, 1'b0, 16'hFFFF, 8'hC7);
    endtask

    task automatic test_back_to_back();
        logic [7:0] dat [3] = '{8'h11, 8'h22, 8'h33};
        int t [3] = '{0, 0, 0};
        int idx = 0, nrsp = 0, cyc = 0;
        logic acc;
        req_write[0] = 1'b1; req_addr[0] = 16'h0100; req_wdata[0] = dat[0]; req_valid[0] = 1'b1;
        while ((idx < 3 || nrsp < 3) && cyc < 40) begin
            acc = req_valid[0] && req_ready[0];
            @(posedge CLK); #1;
            cyc++;
            if (acc) begin
                t[idx] = cyc;
                ref_mem[0][16'h0100 + 16'(idx)] = dat[idx];
                idx++;
                if (idx < 3) begin
                    req_addr[0] = 16'h0100 + 16'(idx);
                    req_wdata[0] = dat[idx];
                end else req_valid[0] = 1'b0;
            end
            if (rsp_valid[0] && nrsp < 3) begin
                checks++;
                if ({rsp_write[0], rsp_rdata[0], 32'(cyc)} !== {1'b1, 8'h00, 32'(t[nrsp] + 2)}) begin
                    errors++;
                    $display("FAIL b2b_rsp n=%0d got=%b/%h@%0d want=1/00@%0d", nrsp, rsp_write[0], rsp_rdata[0],
                             cyc, t[nrsp] + 2);
                end
                nrsp++;
            end
        end
        req_valid[0] = 1'b0;
        checks++;
        if (idx != 3 || nrsp != 3) begin
            errors++;
            $display("FAIL b2b_count got=%0d/%0d want=3/3", idx, nrsp);
        end
        checks++;
        if (t[1] - t[0] != 4 || t[2] - t[1] != 4) begin
            errors++;
            $display("FAIL b2b_spacing got=%0d,%0d want=4,4", t[1] - t[0], t[2] - t[1]);
        end
        for (int i = 0; i < 3; i++) do_txn(0, 1'b0, 16'h0100 + 16'(i), 8'(i));
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 16'hFFFF;
        @(posedge CLK); #1;
        req_valid[1] = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (m_oeb[1] !== 1'b0) begin
            errors++;
            $display("FAIL strobe_before_reset got=%b want=0", m_oeb[1]);
        end
        rst[1] = 1'b1;
        @(posedge CLK); #1;
        rst[1] = 1'b0;
        checks++;
        if (obs(1) !== IDLE_PINS) begin
            errors++;
            $display("FAIL reset_mid got=%h want=%h", obs(1), IDLE_PINS);
        end
        repeat (10) begin
            @(posedge CLK); #1;
            if (rsp_valid[1] || !m_oeb[1]) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL dropped_request got=%0d want=0", seen);
        end
    endtask

`ifdef MEMHOST_RSP_BP_EN
    task automatic test_backpressure();
        int n = 0;
        logic [7:0] exp_rd;
        exp_rd = ref_mem[1][16'hFFFF];
        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 16'hFFFF;
        @(posedge CLK); #1;
        req_valid[1] = 1'b0;
        while (!rsp_valid[1] && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({obs(1), rsp_rdata[1]} !== {pins(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0, 8'h0), exp_rd}) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got=%h/%h want=%h/%h", i, obs(1), rsp_rdata[1],
                         pins(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0, 8'h0), exp_rd);
            end
            if (i == 4) rsp_ready[1] = 1'b1;
            @(posedge CLK); #1;
        end
        checks++;
        if (obs(1) !== IDLE_PINS) begin
            errors++;
            $display("FAIL bp_release got=%h want=%h", obs(1), IDLE_PINS);
        end
    endtask
`endif

    task automatic test_random();
        logic [16:0] used [$];
        logic [16:0] e;
        int k;
        logic [15:0] a;
        for (int i = 0; i < 30; i++) begin
            if (used.size() == 0 || $urandom_range(0, 2) == 0) begin
                k = int'($urandom_range(0, 1));
                a = 16'($urandom);
                do_txn(k, 1'b1, a, 8'($urandom));
                used.push_back({1'(k), a});
            end else begin
                e = used[$urandom_range(0, used.size() - 1)];
                do_txn(int'(e[16]), 1'b0, e[15:0], 8'($urandom));
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0;
            req_addr[k] = 16'h0000; req_wdata[k] = 8'h00;
`ifdef MEMHOST_RSP_BP_EN
            rsp_ready[k] = 1'b1;
`endif
        end
        test_reset();
        test_write_read();
        test_back_to_back();
        test_reset_mid();
`ifdef MEMHOST_RSP_BP_EN
        test_backpressure();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
